// File: rtl/floatmul_arb_if.sv
// Bundle of the requester channels, the broadcast response and the three
// multiplier channels that floatmul_arb sits between.
interface floatmul_arb_if #(
  parameter int N_REQ = 4
);
  logic                         busy;
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][32:0]       req_a;
  logic [N_REQ-1:0][32:0]       req_b;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0]             rsp_valid;
  logic [32:0]                  rsp_payload;
  logic [N_REQ-1:0]             rsp_ready;
  logic                         mul_a_valid;
  logic [32:0]                  mul_a_payload;
  logic                         mul_a_ready;
  logic                         mul_b_valid;
  logic [32:0]                  mul_b_payload;
  logic                         mul_b_ready;
  logic                         mul_o_valid;
  logic [32:0]                  mul_o_payload;
  logic                         mul_o_ready;

  modport slave (
    output busy,
    input  req_valid, req_a, req_b,
    output req_ready,
    output rsp_valid, rsp_payload,
    input  rsp_ready,
    output mul_a_valid, mul_a_payload,
    input  mul_a_ready,
    output mul_b_valid, mul_b_payload,
    input  mul_b_ready,
    input  mul_o_valid, mul_o_payload,
    output mul_o_ready
  );

  modport master (
    input  busy,
    output req_valid, req_a, req_b,
    input  req_ready,
    input  rsp_valid, rsp_payload,
    output rsp_ready,
    input  mul_a_valid, mul_a_payload,
    output mul_a_ready,
    input  mul_b_valid, mul_b_payload,
    output mul_b_ready,
    output mul_o_valid, mul_o_payload,
    input  mul_o_ready
  );
endinterface

// File: rtl/floatmul_arb.sv
// Round-robin sharing of one multiplier among N_REQ requesters; an in-order
// tag FIFO steers each result back to the requester that issued the pair.
module floatmul_arb #(
  parameter int N_REQ           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          rst,
  floatmul_arb_if.slave bus
);
  localparam int GW = $clog2(N_REQ);
  localparam int PW = $clog2(MAX_OUTSTANDING);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                                state_q, state_d;
  logic [GW-1:0]                         grant_q, grant_d;
  logic [GW-1:0]                         rr_q, rr_d;
  logic                                  a_done_q, a_done_d;
  logic                                  b_done_q, b_done_d;
  logic [MAX_OUTSTANDING-1:0][GW-1:0]    tag_q;
  logic [PW-1:0]                         wr_q, rd_q;
  logic [PW:0]                           cnt_q;

  logic          found, a_hs, b_hs, complete, push, pop, fifo_empty, fifo_full;
  logic [GW-1:0] pick, head;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (PW+1)'(MAX_OUTSTANDING));
  assign head       = tag_q[rd_q];
  assign a_hs       = bus.mul_a_valid & bus.mul_a_ready;
  assign b_hs       = bus.mul_b_valid & bus.mul_b_ready;
  assign complete   = (state_q == ISSUE) & (a_done_q | a_hs) & (b_done_q | b_hs);
  assign push       = complete;
  assign pop        = ~fifo_empty & bus.mul_o_valid & bus.mul_o_ready;

  // First valid requester at or after rr_q, wrapping.
  always_comb begin : arb_pick
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      tag_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
      if (push) begin
        tag_q[wr_q] <= grant_q;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    a_done_d = a_done_q;
    b_done_d = b_done_q;
    case (state_q)
      IDLE: begin
        // Slot is reserved here, so the push on completion cannot overflow.
        if (found && !fifo_full) begin
          grant_d = pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (complete) begin
          state_d  = IDLE;
          rr_d     = (grant_q == GW'(N_REQ-1)) ? '0 : grant_q + 1'b1;
          a_done_d = 1'b0;
          b_done_d = 1'b0;
        end else begin
          a_done_d = a_done_q | a_hs;
          b_done_d = b_done_q | b_hs;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy          = (state_q != IDLE) | ~fifo_empty;
    bus.mul_a_valid   = 1'b0;
    bus.mul_b_valid   = 1'b0;
    bus.mul_a_payload = '0;
    bus.mul_b_payload = '0;
    bus.req_ready     = '0;
    bus.rsp_valid     = '0;
    bus.rsp_payload   = '0;
    bus.mul_o_ready   = 1'b0;
    if (state_q == ISSUE) begin
      bus.mul_a_valid   = ~a_done_q;
      bus.mul_b_valid   = ~b_done_q;
      bus.mul_a_payload = bus.req_a[grant_q];
      bus.mul_b_payload = bus.req_b[grant_q];
    end
    if (complete) bus.req_ready[grant_q] = 1'b1;
    // With no tag outstanding a result is stalled rather than dropped.
    if (!fifo_empty) begin
      bus.rsp_valid[head] = bus.mul_o_valid;
      bus.rsp_payload     = bus.mul_o_payload;
      bus.mul_o_ready     = bus.rsp_ready[head];
    end
  end
endmodule
